// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and its read-side sequencer.
package reg_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 4;

endpackage

// File: rtl/reg_file.sv
// Small register file: one synchronous write port, two combinational read ports.
module reg_file import reg_file_pkg::*; #(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int NumRegs    = DEFAULT_NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  writeEn,
    input  logic [IndexWidth-1:0] writeAddr,
    input  logic [DataWidth-1:0]  writeData,
    input  logic [IndexWidth-1:0] readAddr1,
    output logic [DataWidth-1:0]  readData1,
    input  logic [IndexWidth-1:0] readAddr2,
    output logic [DataWidth-1:0]  readData2
);

    logic [DataWidth-1:0] r_regs [NumRegs];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            r_regs[writeAddr] <= writeData;
        end
    end

    assign readData1 = r_regs[readAddr1];
    assign readData2 = r_regs[readAddr2];

endmodule

// File: rtl/stream_out_reg.sv
// One-entry output register for a valid/ready stream; holds its beat until accepted.
module stream_out_reg #(
    parameter int DataWidth  = 32,
    parameter int IndexWidth = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DataWidth-1:0]  i_data,
    input  logic [IndexWidth-1:0] i_index,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DataWidth-1:0]  o_data,
    output logic [IndexWidth-1:0] o_index,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DataWidth-1:0]  r_data;
    logic [IndexWidth-1:0] r_index;
    logic                  r_last;

    // A load always wins; without one, an accepted beat simply empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_index = r_index;
    assign o_last  = r_last;

endmodule

// File: rtl/reg_file_reader.sv
// Walks a range of register indices through one read port and streams the
// contents out with index and last flag on a back-pressurable valid/ready port.
module reg_file_reader import reg_file_pkg::*; #(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int NumRegs    = DEFAULT_NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IndexWidth-1:0] startIdx,
    input  logic [IndexWidth:0]   count,
    output logic [IndexWidth-1:0] readAddr,
    input  logic [DataWidth-1:0]  readData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DataWidth-1:0]  outData,
    output logic [IndexWidth-1:0] outIndex,
    output logic                  outLast,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);
    localparam logic [IndexWidth:0]   RemOne  = (IndexWidth+1)'(1);

    state_t                r_state;
    logic [IndexWidth-1:0] r_rdPtr;
    logic [IndexWidth:0]   r_remaining;
    logic                  r_done;

    logic                  w_load;
    logic                  w_last;
    logic [IndexWidth-1:0] w_nextPtr;

    // Loading only when the output slot is empty or emptying keeps the
    // pointer frozen for as long as the consumer stalls.
    assign w_load    = (r_state == RUN) && (!outValid || outReady);
    assign w_last    = (r_remaining == RemOne);
    assign w_nextPtr = (r_rdPtr == LastIdx) ? '0 : r_rdPtr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rdPtr     <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rdPtr     <= startIdx;
                        r_remaining <= count;
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_load) begin
                        r_rdPtr     <= w_nextPtr;
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (outReady) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    stream_out_reg #(
        .DataWidth (DataWidth),
        .IndexWidth(IndexWidth)
    ) u_out (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (readData),
        .i_index(r_rdPtr),
        .i_last (w_last),
        .i_ready(outReady),
        .o_valid(outValid),
        .o_data (outData),
        .o_index(outIndex),
        .o_last (outLast)
    );

    assign readAddr = r_rdPtr;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader attached to reg_file through read port 1.
module tb_reg_file_reader;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] startIdx;
    logic [IW:0]   count;
    logic [IW-1:0] readAddr;
    logic [DW-1:0] readData;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outData;
    logic [IW-1:0] outIndex;
    logic          outLast;
    logic          busy;
    logic          done;
    logic          writeEn;
    logic [IW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic [IW-1:0] rd2Addr;
    logic [DW-1:0] rd2Data;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] rf_init [4] = '{32'h11, 32'h22, 32'h0A0A, 32'h0505};

    logic [DW-1:0] bd [16];
    logic [IW-1:0] bi [16];
    logic          bl [16];
    int            bt [16];
    int            nbeats;
    int            done_t;
    int            done_cnt;
    logic          busy_at_done;

    always #5 clk = ~clk;

    reg_file_reader #(.DataWidth(DW), .NumRegs(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .startIdx(startIdx), .count(count),
        .readAddr(readAddr), .readData(readData), .outValid(outValid),
        .outReady(outReady), .outData(outData), .outIndex(outIndex),
        .outLast(outLast), .busy(busy), .done(done)
    );

    reg_file #(.DataWidth(DW), .NumRegs(NR)) u_rf (
        .clk(clk), .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .readAddr1(readAddr), .readData1(readData),
        .readAddr2(rd2Addr), .readData2(rd2Data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_reg(input logic [IW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        writeEn = 1'b1; writeAddr = a; writeData = d;
        @(negedge clk);
        writeEn = 1'b0;
    endtask

    task automatic do_start(input int idx, input int cnt);
        @(negedge clk);
        start = 1'b1; startIdx = IW'(idx); count = (IW+1)'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records accepted beats with outReady held high; sample t is just after edge N+t.
    task automatic collect(input int max_t);
        nbeats = 0; done_cnt = 0; done_t = -1; busy_at_done = 1'bx;
        for (int i = 0; i < 16; i++) begin
            bd[i] = 'x; bi[i] = 'x; bl[i] = 1'bx; bt[i] = -1;
        end
        outReady = 1'b1;
        for (int t = 0; t < max_t; t++) begin
            if (outValid && outReady) begin
                if (nbeats < 16) begin
                    bd[nbeats] = outData; bi[nbeats] = outIndex;
                    bl[nbeats] = outLast; bt[nbeats] = t;
                end
                nbeats++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) begin
                    done_t = t; busy_at_done = busy;
                end
            end
            if (done_t >= 0 && t >= done_t + 2) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; startIdx = '0; count = '0; outReady = 1'b1;
        writeEn = 1'b0; writeAddr = '0; writeData = '0; rd2Addr = '0;
        repeat (2) @(negedge clk);
        n_total++; if ({outValid, outLast, busy, done} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {outValid, outLast, busy, done}); else n_pass++;
        n_total++; if (outData !== '0) $display("FAIL reset_data: got %h want 0", outData); else n_pass++;
        n_total++; if (outIndex !== '0) $display("FAIL reset_index: got %0d want 0", outIndex); else n_pass++;
        n_total++; if (readAddr !== '0) $display("FAIL reset_readAddr: got %0d want 0", readAddr); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) write_reg(IW'(i), rf_init[i]);
    endtask

    task automatic test_full_dump();
        do_start(0, 4);
        n_total++; if ({busy, readAddr} !== {1'b1, 2'd0})
            $display("FAIL dump_start: busy/readAddr got %b/%0d want 1/0", busy, readAddr); else n_pass++;
        collect(20);
        n_total++; if (nbeats !== 4) $display("FAIL dump_nbeats: got %0d want 4", nbeats); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({bi[i], bd[i], bl[i]} !== {IW'(i), rf_init[i], (i == 3)})
                $display("FAIL dump_beat%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, bi[i], bd[i], bl[i], i, rf_init[i], (i == 3));
            else n_pass++;
            n_total++; if (bt[i] !== i + 1) $display("FAIL dump_time%0d: got %0d want %0d", i, bt[i], i + 1); else n_pass++;
        end
        n_total++; if (done_t !== 5) $display("FAIL dump_done_time: got %0d want 5", done_t); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL dump_done_width: got %0d want 1", done_cnt); else n_pass++;
        n_total++; if (busy_at_done !== 1'b0) $display("FAIL dump_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [IW-1:0] ei [3] = '{2'd3, 2'd0, 2'd1};
        do_start(3, 3);
        collect(20);
        n_total++; if (nbeats !== 3) $display("FAIL wrap_nbeats: got %0d want 3", nbeats); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({bi[i], bd[i], bl[i]} !== {ei[i], rf_init[ei[i]], (i == 2)})
                $display("FAIL wrap_beat%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, bi[i], bd[i], bl[i], ei[i], rf_init[ei[i]], (i == 2));
            else n_pass++;
        end
        n_total++; if (done_t !== 4) $display("FAIL wrap_done_time: got %0d want 4", done_t); else n_pass++;
    endtask

    task automatic test_backpressure();
        int stall = 0;
        bit stalled = 0;
        int n = 0;
        int dt = -1;
        logic [DW-1:0] gd [8];
        logic [IW-1:0] gi [8];
        logic          gl [8];
        for (int i = 0; i < 8; i++) begin gd[i] = 'x; gi[i] = 'x; gl[i] = 1'bx; end
        do_start(0, 4);
        for (int t = 0; t < 40; t++) begin
            writeEn = 1'b0;
            if (outValid && outIndex == 2'd2 && !stalled) begin
                stalled = 1; stall = 3;
                writeEn = 1'b1; writeAddr = 2'd2; writeData = 32'hBEEF;
            end
            outReady = (stall == 0);
            if (stall > 0) begin
                n_total++;
                if ({outValid, outIndex, outLast, outData} !== {1'b1, 2'd2, 1'b0, 32'h0A0A})
                    $display("FAIL bp_hold t=%0d: got v%b idx %0d last %b data %h want v1 idx 2 last 0 data 0a0a",
                             t, outValid, outIndex, outLast, outData);
                else n_pass++;
                n_total++; if (readAddr !== 2'd3) $display("FAIL bp_readAddr t=%0d: got %0d want 3", t, readAddr); else n_pass++;
                stall--;
            end
            if (outValid && outReady) begin
                if (n < 8) begin gd[n] = outData; gi[n] = outIndex; gl[n] = outLast; end
                n++;
            end
            if (done === 1'b1 && dt < 0) dt = t;
            if (dt >= 0 && t >= dt + 1) break;
            @(negedge clk);
        end
        writeEn = 1'b0; outReady = 1'b1;
        n_total++; if (stalled !== 1'b1) $display("FAIL bp_stall_seen: got %b want 1", stalled); else n_pass++;
        n_total++; if (n !== 4) $display("FAIL bp_nbeats: got %0d want 4", n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({gi[i], gd[i], gl[i]} !== {IW'(i), rf_init[i], (i == 3)})
                $display("FAIL bp_beat%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, gi[i], gd[i], gl[i], i, rf_init[i], (i == 3));
            else n_pass++;
        end
        n_total++; if (dt !== 8) $display("FAIL bp_done_time: got %0d want 8", dt); else n_pass++;
        write_reg(2'd2, rf_init[2]);
    endtask

    task automatic test_count_zero();
        int ov = 0;
        do_start(0, 0);
        n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
        n_total++; if ({busy, outValid} !== 2'b00) $display("FAIL zero_busy_valid: got %b want 00", {busy, outValid}); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else n_pass++;
        repeat (3) begin
            if (outValid !== 1'b0) ov++;
            @(negedge clk);
        end
        n_total++; if (ov !== 0) $display("FAIL zero_no_beats: got %0d valid cycles want 0", ov); else n_pass++;
    endtask

    task automatic test_start_busy();
        int n = 0;
        int dt = -1;
        logic [IW-1:0] gi [8];
        logic [DW-1:0] gd [8];
        for (int i = 0; i < 8; i++) begin gi[i] = 'x; gd[i] = 'x; end
        do_start(0, 4);
        outReady = 1'b1;
        for (int t = 0; t < 30; t++) begin
            start = (t == 2 || t == 4);
            startIdx = 2'd3; count = 3'd1;
            if (outValid && outReady) begin
                if (n < 8) begin gi[n] = outIndex; gd[n] = outData; end
                n++;
            end
            if (done === 1'b1 && dt < 0) dt = t;
            if (dt >= 0 && t == dt + 1) begin
                n_total++; if ({busy, outValid} !== 2'b00)
                    $display("FAIL busy_start_after_done: got %b want 00", {busy, outValid}); else n_pass++;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_total++; if (n !== 4) $display("FAIL busy_start_nbeats: got %0d want 4", n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({gi[i], gd[i]} !== {IW'(i), rf_init[i]})
                $display("FAIL busy_start_beat%0d: got idx %0d data %h want idx %0d data %h", i, gi[i], gd[i], i, rf_init[i]);
            else n_pass++;
        end
        n_total++; if (dt !== 5) $display("FAIL busy_start_done_time: got %0d want 5", dt); else n_pass++;
    endtask

    task automatic test_overlength();
        logic [IW-1:0] ei [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_start(0, 6);
        collect(30);
        n_total++; if (nbeats !== 6) $display("FAIL over_nbeats: got %0d want 6", nbeats); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if ({bi[i], bd[i], bl[i]} !== {ei[i], rf_init[ei[i]], (i == 5)})
                $display("FAIL over_beat%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, bi[i], bd[i], bl[i], ei[i], rf_init[ei[i]], (i == 5));
            else n_pass++;
        end
        n_total++; if (done_t !== 7) $display("FAIL over_done_time: got %0d want 7", done_t); else n_pass++;
    endtask

    task automatic test_reset_midwalk();
        int dc = 0;
        int ov = 0;
        do_start(0, 4);
        outReady = 1'b1;
        @(negedge clk);
        n_total++; if ({outValid, outIndex} !== {1'b1, 2'd0})
            $display("FAIL rstmid_beat0: got v%b idx %0d want v1 idx 0", outValid, outIndex); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({outValid, outLast, busy, done, outIndex, readAddr, outData} !== '0)
            $display("FAIL rstmid_async: got v%b last %b busy %b done %b idx %0d addr %0d data %h want all 0",
                     outValid, outLast, busy, done, outIndex, readAddr, outData);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0) dc++;
            if (outValid !== 1'b0) ov++;
        end
        n_total++; if (dc !== 0) $display("FAIL rstmid_no_done: got %0d done cycles want 0", dc); else n_pass++;
        n_total++; if (ov !== 0) $display("FAIL rstmid_no_valid: got %0d valid cycles want 0", ov); else n_pass++;
        do_start(0, 4);
        collect(20);
        n_total++; if (nbeats !== 4) $display("FAIL rstmid_nbeats: got %0d want 4", nbeats); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({bi[i], bd[i], bl[i]} !== {IW'(i), rf_init[i], (i == 3)})
                $display("FAIL rstmid_beat%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, bi[i], bd[i], bl[i], i, rf_init[i], (i == 3));
            else n_pass++;
        end
        n_total++; if (done_t !== 5) $display("FAIL rstmid_done_time: got %0d want 5", done_t); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_count_zero();
        test_start_busy();
        test_overlength();
        test_reset_midwalk();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_reader.md
# reg_file_reader

Read-side sequencer for the register file: on a start command it walks a range of register indices through one register-file read port and streams each register's contents out on a valid/ready interface. The output stream carries the index and a last flag, and is fully back-pressurable.

It sits between the register file's read port and any consumer of register contents, such as a debug dump or a context-save path. It is the reading counterpart to the blocks that drive the write port.

## Interface
- DataWidth, 32, register width in bits
- NumRegs, 4, number of registers in the attached register file
- IndexWidth, $clog2(NumRegs), register index width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a walk; ignored while busy
- startIdx  in  IndexWidth  first register index of the walk
- count  in  IndexWidth+1  number of beats to emit
- readAddr  out  IndexWidth  drives the register file read address
- readData  in  DataWidth  combinational read data from the register file
- outValid  out  1  outData, outIndex and outLast are valid
- outReady  in  1  consumer accepts the beat on the current edge
- outData  out  DataWidth  register contents
- outIndex  out  IndexWidth  index the data was read from
- outLast  out  1  final beat of the walk
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a walk completes

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: reading and loading beats.
  - DRAIN: waiting for the last beat to be accepted.
- IDLE, start=1:
  - Latch rdPtr=startIdx and remaining=count.
  - If count=0: go to IDLE, assert done next cycle, emit no beats.
  - Otherwise: go to RUN.
- readAddr = rdPtr at all times; it is 0 in IDLE after reset.
- RUN: on each edge where load = (!outValid || outReady):
  - Load outData=readData, outIndex=rdPtr, outLast=(remaining==1), outValid=1.
  - Advance rdPtr modulo NumRegs; wraps from NumRegs-1 to 0, including non-power-of-two NumRegs.
  - Decrement remaining.
  - When remaining becomes 0, go to DRAIN.
- DRAIN: outValid held until outReady. On the last handshake: outValid=0, go to IDLE, done=1 for exactly one cycle.
- count > NumRegs is legal: indices wrap and registers are re-read.
- Output hold rule: while outValid=1 and outReady=0, outData, outIndex and outLast hold stable, and rdPtr does not advance.
- Data is sampled at load time. A register-file write to the same index after its beat was loaded does not alter the held beat.
- start while busy is ignored, with no effect on the current walk.

## Timing
- Reset values: readAddr=0, outValid=0, outData=0, outIndex=0, outLast=0, busy=0, done=0, state=IDLE.
- Start sampled at edge N: busy=1 and readAddr=startIdx from N. First beat valid after edge N+1.
- Throughput is one beat per cycle when outReady is held high.
- A walk of C beats with no backpressure runs:
  - last beat valid after edge N+C;
  - done high after edge N+C+1, with busy=0 in the same cycle.
- Last handshake and a new start on the same edge: start is ignored, because busy=1.
- Reset mid-walk: all outputs return to reset values immediately (asynchronous). The partial beat is dropped and no done is issued.

## Structure
- Shared package reg_file_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - default DataWidth and NumRegs constants, shared with reg_file.
- Sub-module stream_out_reg holds the one-entry output register with the valid/ready hold logic (data, index, last).
- The FSM and pointer logic stay in the top level.
- The bench instantiates reg_file and connects its readAddr1/readData1 port to this block.

## Test plan
Register file preloaded with reg0..reg3 = 0x11, 0x22, 0x0A0A, 0x0505 unless stated.
- Full dump: start with startIdx=0, count=4, outReady=1.
  - Beats: (0,0x11), (1,0x22), (2,0x0A0A), (3,0x0505); outLast only on the 4th beat.
  - done one cycle after the last beat.
- Wrap: startIdx=3, count=3.
  - Indices 3, 0, 1 with data 0x0505, 0x11, 0x22.
- Backpressure: full dump with outReady low for 3 cycles on beat 2.
  - outData=0x0A0A and outIndex=2 held stable throughout; no beat lost or duplicated; readAddr frozen at 3.
- count=0, and start while busy:
  - count=0 gives no outValid and a done pulse 1 cycle after start.
  - A second start mid-walk leaves the sequence unchanged.
- Overlength: count=6 from startIdx=0.
  - Indices 0, 1, 2, 3, 0, 1; last on the 6th beat.
- Reset mid-walk: assert rst after beat 1.
  - All outputs are 0 asynchronously and no done pulse occurs.
  - A fresh start then yields the full correct sequence.
